// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between instruction fetch and the
//   load/store path. Only one transaction is outstanding at a time. Data requests
//   take priority over fetches. Stores are steered onto byte lanes. Loads are
//   extracted from their lanes and then zero- or sign-extended.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_if_req/i_if_addr/i_flush     fetch request (level-held), fetch cancel
//   o_if_valid/o_if_rdata          one-cycle fetch response
//   i_dm_ren/i_dm_wen/i_dm_addr    load/store request (level-held)
//   i_dm_wdata/i_dm_size/i_dm_unsigned  store data, access size, load extension
//   o_dm_done/o_dm_rdata/o_dm_misaligned  one-cycle data response
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_be/o_mem_wdata  memory request side
//   i_mem_gnt/i_mem_rvalid/i_mem_rdata                  memory response side
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_flush,
  output logic              o_if_valid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_dm_ren,
  input  logic              i_dm_wen,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [31:0]       i_dm_wdata,
  input  logic [1:0]        i_dm_size,
  input  logic              i_dm_unsigned,
  output logic              o_dm_done,
  output logic [31:0]       o_dm_rdata,
  output logic              o_dm_misaligned,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic              r_owner_dm;
  logic              r_flush_pend;
  logic              r_err;
  logic              r_we;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_dm_rdata;

  logic              w_dm_req;
  logic [1:0]        w_a;
  logic              w_misal;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wdata;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;
  logic [31:0]       w_ld_data;

  assign w_dm_req = i_dm_ren | i_dm_wen;
  assign w_a      = i_dm_addr[1:0];

  // Size 11 falls through to the word cases everywhere.
  always_comb begin
    w_misal    = 1'b0;
    w_st_be    = 4'b1111;
    w_st_wdata = i_dm_wdata;
    case (i_dm_size)
      2'b00: begin
        w_st_be    = 4'b0001 << w_a;
        w_st_wdata = {4{i_dm_wdata[7:0]}};
      end
      2'b01: begin
        w_misal    = w_a[0];
        w_st_be    = w_a[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{i_dm_wdata[15:0]}};
      end
      default: begin
        w_misal    = (w_a != 2'b00);
      end
    endcase
  end

  // Load lane extraction uses the byte offset captured with the request.
  always_comb begin
    w_ld_byte = i_mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_ld_byte = i_mem_rdata[15:8];
      2'd2:    w_ld_byte = i_mem_rdata[23:16];
      2'd3:    w_ld_byte = i_mem_rdata[31:24];
      default: w_ld_byte = i_mem_rdata[7:0];
    endcase
    w_ld_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_size)
      2'b00:   w_ld_data = {{24{~r_uns & w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_data = {{16{~r_uns & w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_owner_dm   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dm_req) begin
            r_owner_dm <= 1'b1;
            r_addr     <= i_dm_addr;
            r_we       <= i_dm_wen;
            r_be       <= i_dm_wen ? w_st_be : 4'b1111;
            r_wdata    <= i_dm_wen ? w_st_wdata : '0;
            r_size     <= i_dm_size;
            r_uns      <= i_dm_unsigned;
            r_err      <= w_misal;
            if (w_misal) begin
              r_dm_rdata <= '0;
              r_state    <= S_RESP;
            end else begin
              r_state    <= S_REQ;
            end
          end else if (i_if_req && !i_flush) begin
            r_owner_dm <= 1'b0;
            r_addr     <= i_if_addr;
            r_we       <= 1'b0;
            r_be       <= 4'b1111;
            r_wdata    <= '0;
            r_size     <= 2'b10;
            r_uns      <= 1'b0;
            r_err      <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (!r_owner_dm && i_flush) begin
            r_state <= S_IDLE;
          end else if (i_mem_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A fetch already granted cannot be withdrawn from the memory, so it
          // is allowed to finish and only its response pulse is dropped.
          if (!r_owner_dm && i_flush) begin
            r_flush_pend <= 1'b1;
          end
          if (i_mem_rvalid) begin
            if (r_owner_dm) begin
              r_dm_rdata <= r_we ? '0 : w_ld_data;
            end else begin
              r_if_rdata <= i_mem_rdata;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_flush_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req       = (r_state == S_REQ);
  assign o_mem_we        = r_we;
  assign o_mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_mem_be        = r_be;
  assign o_mem_wdata     = r_wdata;
  assign o_if_valid      = (r_state == S_RESP) && !r_owner_dm && !r_flush_pend;
  assign o_if_rdata      = r_if_rdata;
  assign o_dm_done       = (r_state == S_RESP) && r_owner_dm;
  assign o_dm_misaligned = (r_state == S_RESP) && r_owner_dm && r_err;
  assign o_dm_rdata      = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Expected responses and expected memory-bus
// transactions are queued when stimulus is issued. A monitor pops responses
// when the DUT pulses, and the memory responder pops bus transactions on grant.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_flush;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;
  logic        i_dm_ren;
  logic        i_dm_wen;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [1:0]  i_dm_size;
  logic        i_dm_unsigned;
  logic        o_dm_done;
  logic [31:0] o_dm_rdata;
  logic        o_dm_misaligned;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_flush(i_flush),
    .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
    .i_dm_ren(i_dm_ren), .i_dm_wen(i_dm_wen), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_size(i_dm_size), .i_dm_unsigned(i_dm_unsigned),
    .o_dm_done(o_dm_done), .o_dm_rdata(o_dm_rdata), .o_dm_misaligned(o_dm_misaligned),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    bit          mis;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wd;
  } bus_t;

  resp_t exp_q[$];
  bus_t  bus_q[$];

  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  int n_checks = 0;
  int n_errors = 0;
  int if_pulses = 0;
  int req_cycles = 0;
  int gnt_cnt = 0;

  bit fast = 1'b0;
  bit hold_gnt = 1'b0;
  bit hold_rvalid = 1'b0;
  bit busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // ---------------- reference model (byte-addressed) ----------------
  function automatic logic [7:0] ref_byte(input int unsigned a);
    logic [31:0] w;
    w = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : init_word(a >> 2);
    return w[8*(a%4) +: 8];
  endfunction

  task automatic ref_set_byte(input int unsigned a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : init_word(a >> 2);
    w[8*(a%4) +: 8] = b;
    ref_mem[a >> 2] = w;
  endtask

  function automatic int unsigned nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_dm(input bit wen, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input bit un);
    int unsigned n;
    resp_t r;
    bus_t b;
    logic [31:0] val;
    n = nbytes(sz);
    r.is_dm = 1'b1;
    if ((a % n) != 0) begin
      r.mis = 1'b1;
      r.data = '0;
      exp_q.push_back(r);
      return;
    end
    r.mis = 1'b0;
    b.addr = a & 32'hFFFF_FFFC;
    b.we = wen;
    b.chk_wd = wen;
    b.be = wen ? 4'b0000 : 4'b1111;
    b.wdata = '0;
    if (wen) begin
      for (int unsigned k = 0; k < n; k++) b.be[(a % 4) + k] = 1'b1;
      for (int unsigned l = 0; l < 4; l++) b.wdata[8*l +: 8] = wd[8*(l % n) +: 8];
      for (int unsigned k = 0; k < n; k++) ref_set_byte(a + k, wd[8*k +: 8]);
      r.data = '0;
    end else begin
      val = '0;
      for (int unsigned k = 0; k < n; k++) val = val | ({24'b0, ref_byte(a + k)} << (8*k));
      if (!un && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      r.data = val;
    end
    bus_q.push_back(b);
    exp_q.push_back(r);
  endtask

  task automatic model_if(input logic [31:0] a, input bit want_resp);
    resp_t r;
    bus_t b;
    int unsigned base;
    base = a & 32'hFFFF_FFFC;
    b.addr = base;
    b.we = 1'b0;
    b.be = 4'b1111;
    b.wdata = '0;
    b.chk_wd = 1'b0;
    bus_q.push_back(b);
    r.is_dm = 1'b0;
    r.mis = 1'b0;
    r.data = '0;
    for (int unsigned k = 0; k < 4; k++) r.data[8*k +: 8] = ref_byte(base + k);
    if (want_resp) exp_q.push_back(r);
  endtask

  task automatic preload(input int unsigned a, input logic [31:0] v);
    mem[a >> 2] = v;
    ref_mem[a >> 2] = v;
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    logic [31:0] t_addr, t_wd, w;
    logic [3:0]  t_be;
    bit          t_we;
    int          dly;
    bus_t        b;
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata = '0;
    dly = 0;
    forever begin
      @(negedge clk);
      i_mem_gnt = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata = $urandom;
      if (!rst_n) begin
        busy = 1'b0;
        continue;
      end
      if (busy) begin
        if (!hold_rvalid) begin
          if (dly == 0) begin
            i_mem_rvalid = 1'b1;
            w = mem.exists(t_addr >> 2) ? mem[t_addr >> 2] : init_word(t_addr >> 2);
            if (t_we) begin
              for (int l = 0; l < 4; l++) if (t_be[l]) w[8*l +: 8] = t_wd[8*l +: 8];
              mem[t_addr >> 2] = w;
            end else begin
              i_mem_rdata = w;
            end
            busy = 1'b0;
          end else begin
            dly--;
          end
        end
      end else if (o_mem_req && !hold_gnt && !i_flush && (fast || $urandom_range(0, 2) != 0)) begin
        i_mem_gnt = 1'b1;
        gnt_cnt++;
        busy = 1'b1;
        dly = fast ? 0 : int'($urandom_range(0, 2));
        t_addr = o_mem_addr;
        t_we = o_mem_we;
        t_be = o_mem_be;
        t_wd = o_mem_wdata;
        if (bus_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_grant addr=%h at %0t", o_mem_addr, $time);
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr", o_mem_addr, b.addr);
          chk("bus_we", {31'b0, o_mem_we}, {31'b0, b.we});
          chk("bus_be", {28'b0, o_mem_be}, {28'b0, b.be});
          if (b.chk_wd) chk("bus_wdata", o_mem_wdata, b.wdata);
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (o_mem_req) req_cycles++;
      if (o_if_valid || o_dm_done) begin
        if (o_if_valid) if_pulses++;
        if (o_if_valid && o_dm_done) begin
          n_checks++;
          n_errors++;
          $display("FAIL both_pulses if_valid=1 dm_done=1 required one at %0t", $time);
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_response if_valid=%b dm_done=%b at %0t", o_if_valid, o_dm_done, $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_kind_dm", {31'b0, o_dm_done}, {31'b0, e.is_dm});
          if (e.is_dm) begin
            chk("dm_rdata", o_dm_rdata, e.data);
            chk("dm_misaligned", {31'b0, o_dm_misaligned}, {31'b0, e.mis});
          end else begin
            chk("if_rdata", o_if_rdata, e.data);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run(input bit do_if, input logic [31:0] ia, input bit do_dm, input bit wen,
                     input logic [31:0] da, input logic [31:0] wd, input logic [1:0] sz,
                     input bit un, output int lat);
    bit ip, dp;
    int cyc;
    if (do_dm) model_dm(wen, da, wd, sz, un);
    if (do_if) model_if(ia, 1'b1);
    @(negedge clk);
    i_if_req = do_if;
    i_if_addr = ia;
    i_dm_ren = do_dm & ~wen;
    i_dm_wen = do_dm & wen;
    i_dm_addr = da;
    i_dm_wdata = wd;
    i_dm_size = sz;
    i_dm_unsigned = un;
    ip = do_if;
    dp = do_dm;
    cyc = 0;
    lat = -1;
    while ((ip || dp) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (dp && o_dm_done) begin
        dp = 1'b0;
        i_dm_ren = 1'b0;
        i_dm_wen = 1'b0;
        if (lat < 0) lat = cyc;
      end
      if (ip && o_if_valid) begin
        ip = 1'b0;
        i_if_req = 1'b0;
        if (lat < 0) lat = cyc;
      end
    end
    if (ip || dp) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout if_pending=%b dm_pending=%b required both 0", ip, dp);
      i_if_req = 1'b0;
      i_dm_ren = 1'b0;
      i_dm_wen = 1'b0;
    end
  endtask

  task automatic wait_in_wait_state();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(busy && !o_mem_req) && cyc < 50);
    if (cyc >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_state_timeout busy=%b mem_req=%b", busy, o_mem_req);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, rc, gc, pc;
    bit do_if, do_dm, wen;
    rst_n = 1'b0;
    i_if_req = 1'b0;
    i_if_addr = '0;
    i_flush = 1'b0;
    i_dm_ren = 1'b0;
    i_dm_wen = 1'b0;
    i_dm_addr = '0;
    i_dm_wdata = '0;
    i_dm_size = '0;
    i_dm_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero",
        {31'b0, |{o_if_valid, o_if_rdata, o_dm_done, o_dm_rdata, o_dm_misaligned,
                  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata}}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases at minimum memory latency.
    fast = 1'b1;
    preload(32'h100, 32'h0050_0093);
    run(1, 32'h100, 0, 0, 0, 0, 2'b10, 0, lat);
    chk("fetch_latency", lat, 32'd3);
    run(1, 32'h10, 1, 0, 32'h204, 0, 2'b10, 0, lat);
    chk("simul_first_latency", lat, 32'd3);
    run(0, 0, 1, 1, 32'h203, 32'h0000_00AB, 2'b00, 0, lat);
    preload(32'h200, 32'h8001_FFFF);
    run(0, 0, 1, 0, 32'h202, 0, 2'b01, 0, lat);
    run(0, 0, 1, 0, 32'h202, 0, 2'b01, 1, lat);
    rc = req_cycles;
    gc = gnt_cnt;
    run(0, 0, 1, 0, 32'h206, 0, 2'b10, 0, lat);
    chk("misaligned_latency", lat, 32'd1);
    chk("misaligned_no_req", req_cycles, rc);
    chk("misaligned_no_gnt", gnt_cnt, gc);

    // Flush in IDLE blocks capture.
    @(negedge clk);
    i_if_req = 1'b1;
    i_if_addr = 32'h40;
    i_flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_no_req", {31'b0, o_mem_req}, 32'd0);
    i_if_req = 1'b0;
    i_flush = 1'b0;

    // Flush in REQ abandons the fetch.
    hold_gnt = 1'b1;
    @(negedge clk);
    i_if_req = 1'b1;
    i_if_addr = 32'h44;
    @(negedge clk);
    chk("flush_req_before", {31'b0, o_mem_req}, 32'd1);
    i_flush = 1'b1;
    i_if_req = 1'b0;
    @(negedge clk);
    chk("flush_req_after", {31'b0, o_mem_req}, 32'd0);
    i_flush = 1'b0;
    hold_gnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_req_stays_idle", {31'b0, o_mem_req}, 32'd0);

    // Flush in WAIT: transaction completes, pulse suppressed.
    pc = if_pulses;
    hold_rvalid = 1'b1;
    model_if(32'h48, 1'b0);
    @(negedge clk);
    i_if_req = 1'b1;
    i_if_addr = 32'h48;
    wait_in_wait_state();
    i_flush = 1'b1;
    i_if_req = 1'b0;
    @(negedge clk);
    #1;
    i_flush = 1'b0;
    hold_rvalid = 1'b0;
    repeat (6) @(negedge clk);
    chk("flush_wait_no_if_valid", if_pulses, pc);
    chk("flush_wait_mem_done", {31'b0, busy}, 32'd0);
    run(1, 32'h4C, 0, 0, 0, 0, 2'b10, 0, lat);
    chk("after_flush_latency", lat, 32'd3);

    // Reset asserted in WAIT clears every output at once.
    hold_rvalid = 1'b1;
    model_dm(1'b0, 32'h208, 0, 2'b10, 1'b0);
    @(negedge clk);
    i_dm_ren = 1'b1;
    i_dm_addr = 32'h208;
    i_dm_size = 2'b10;
    wait_in_wait_state();
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_in_wait_outputs_zero",
        {31'b0, |{o_if_valid, o_if_rdata, o_dm_done, o_dm_rdata, o_dm_misaligned,
                  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata}}, 32'd0);
    i_dm_ren = 1'b0;
    exp_q.delete();
    hold_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic with variable grant and response delays.
    fast = 1'b0;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 2))
        0:       begin do_if = 1'b1; do_dm = 1'b0; end
        1:       begin do_if = 1'b0; do_dm = 1'b1; end
        default: begin do_if = 1'b1; do_dm = 1'b1; end
      endcase
      wen = $urandom_range(0, 1);
      run(do_if, 32'h200 + $urandom_range(0, 255), do_dm, wen,
          32'h200 + $urandom_range(0, 255), $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), lat);
    end

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", exp_q.size(), 32'd0);
    chk("bus_queue_drained", bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported unified memory between the instruction-fetch stage and the load/store path of one core. It accepts level-held requests from both sides and issues one transaction at a time over a req/gnt/rvalid memory handshake. For data accesses it builds byte enables from the store size and extracts and extends load data from the load size and signedness. Decoder outputs (mem write enable, mem-to-reg, store/load size select, load unsigned) drive its data-side inputs directly.

## Interface
- ADDR_W, 32, byte address width.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_if_req  in  1  fetch request; held until o_if_valid or i_flush.
- i_if_addr  in  ADDR_W  fetch address; word aligned, [1:0] ignored.
- i_flush  in  1  cancels any fetch not yet returned.
- o_if_valid  out  1  one-cycle pulse; o_if_rdata is valid.
- o_if_rdata  out  32  fetched instruction.
- i_dm_ren / i_dm_wen  in  1 each  load / store request; held until o_dm_done; never both high.
- i_dm_addr  in  ADDR_W  data byte address.
- i_dm_wdata  in  32  store data, right-aligned.
- i_dm_size  in  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 is treated as word.
- i_dm_unsigned  in  1  load zero-extends when 1 (funct3[2]).
- o_dm_done  out  1  one-cycle pulse; access complete.
- o_dm_rdata  out  32  extended load data; 0 for stores.
- o_dm_misaligned  out  1  qualifies o_dm_done; access not performed.
- o_mem_req  out  1  memory request, held until granted.
- o_mem_we  out  1  write when 1.
- o_mem_addr  out  ADDR_W  word address: byte address with [1:0] = 00.
- o_mem_be  out  4  byte enables; 4'b1111 for reads.
- o_mem_wdata  out  32  lane-aligned write data.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid  in  1  read data or write ack; i_mem_rdata valid.
- i_mem_rdata  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE. Reset values: all outputs 0; internal owner, address, and flush-pending flag are 0.
- IDLE:
  - If a data request is present, capture its address, we, be, wdata, size, unsigned, and owner=DM. Data requests win because they belong to an older instruction.
  - Otherwise, if i_if_req is high and i_flush is low, capture the fetch request with owner=IF.
  - If the captured data access is misaligned, go to RESP with the error flag set and issue no memory access. Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise go to REQ. With no request, stay in IDLE.
- REQ: drive o_mem_req=1 from the captured registers. Move to WAIT on i_mem_gnt. i_mem_rvalid is ignored in REQ.
- WAIT: o_mem_req=0. On i_mem_rvalid, register the formatted response and go to RESP.
- RESP:
  - Pulse o_if_valid or o_dm_done for one cycle with registered data, then return to IDLE.
  - New requests are not sampled in RESP, so a requester may drop or change its request during the pulse cycle.
- Store lane generation, with a = addr[1:0]:
  - Byte: be = 1<<a, wdata = {4{wdata[7:0]}}.
  - Half: be = a[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - Word: be = 1111, wdata unchanged.
- Load extraction:
  - Byte: select rdata[8a+7:8a].
  - Half: select rdata[31:16] if a[1], else rdata[15:0].
  - Extend with zeros if unsigned, otherwise with the sign bit.
- Flush behaviour:
  - i_flush in IDLE blocks fetch capture that cycle.
  - i_flush in REQ with owner=IF returns to IDLE; o_mem_req drops the next cycle.
  - i_flush in WAIT with owner=IF sets flush-pending. The transaction still completes, but the RESP pulse on o_if_valid is suppressed and flush-pending is cleared.
  - i_flush never affects a data transaction.
- Reset asserted mid-transaction returns to IDLE immediately with all outputs 0. The memory is reset by the same i_rst_n, so no stale rvalid follows.

## Timing
- Minimum latency: request seen in cycle 0; o_mem_req high in cycle 1; gnt in cycle 1; rvalid in cycle 2; done/valid pulse in cycle 3.
- Each extra gnt-wait cycle adds one cycle; each extra rvalid-wait cycle adds one cycle.
- Misaligned data access: o_dm_done and o_dm_misaligned pulse in cycle 1.
- Back-to-back transactions: the next transaction is sampled in the IDLE cycle after RESP, so throughput is at most one access per 4 cycles.
- Memory outputs hold constant while o_mem_req=1.

## Test plan
- Fetch only: addr 0x100, gnt in cycle 1, rdata 0x00500093 in cycle 2 -> o_if_valid pulses in cycle 3 with 0x00500093; o_mem_be=1111; o_mem_we=0.
- Simultaneous requests: load addr 0x204 and fetch addr 0x10 in the same cycle -> data access issued first with o_dm_done; fetch issued in the following IDLE; o_if_valid follows.
- Store byte: addr 0x203, wdata 0x000000AB -> o_mem_be=1000, o_mem_wdata=0xABABABAB, o_mem_addr=0x200, o_mem_we=1.
- Load half signed, addr 0x202, rdata 0x8001FFFF -> o_dm_rdata=0xFFFF8001. Same access with unsigned=1 -> 0x00008001.
- Misaligned word load at 0x206 -> o_dm_done and o_dm_misaligned in cycle 1; o_mem_req stays 0.
- Flush in WAIT during a fetch -> transaction completes, o_if_valid never pulses, FSM returns to IDLE. Reset asserted in WAIT -> all outputs 0 in the same cycle.
